// File: rtl/fifo_push_arb_pkg.sv
// Shared definitions for the fifo push arbiter.
//   arb_state_e : ARB/LOCK states of the optional burst-lock FSM
//   idx_width() : width of a requester index
//   crd_width() : width of a credit count able to hold 0..FIFO_DEPTH
package fifo_push_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int crd_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_priority_select.sv
// Combinational rotate-priority picker.
//   i_req   : request vector
//   i_ptr   : index of the last winner; the search starts at i_ptr+1
//   o_grant : one-hot grant (zero when nothing requests)
//   o_idx   : binary index of the winner
//   o_any   : at least one request was granted
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    localparam int unsigned N = NUM_REQ;

    logic [IDX_W-1:0] cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        cand    = '0;
        // Offsets 1..N visit every index once, ending at the pointer itself.
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IDX_W'((32'(i_ptr) + off) % N);
            if (!o_any && i_req[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers,
// with credit-based flow control so a word is only granted when the fifo
// has a guaranteed free slot.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_req/i_req_data  : per-requester valid and data lane (lane k at k*DATA_WIDTH)
//   i_req_last        : last word of a burst (burst-lock build only)
//   o_grant           : one-hot grant, word k accepted this cycle
//   o_push/o_push_data/o_push_src : registered fifo write, one cycle after grant
//   i_fifo_pop        : copy of the fifo pop, returns credit
//   i_fifo_full       : fifo full, only used for the overflow check
//   o_credit          : free fifo slots not yet committed
//   o_err             : sticky overflow flag
// Build option: define FIFO_PUSH_ARB_LOCK_EN to hold the grant on one
// requester until it presents a word with i_req_last set.
module fifo_push_arbiter
    import fifo_push_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 128,
    localparam int IDX_W      = idx_width(NUM_REQ),
    localparam int CRD_W      = crd_width(FIFO_DEPTH)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_push,
    output logic [DATA_WIDTH-1:0]         o_push_data,
    output logic [IDX_W-1:0]              o_push_src,
    input  logic                          i_fifo_pop,
    input  logic                          i_fifo_full,
    output logic [CRD_W-1:0]              o_credit,
    output logic                          o_err
);

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      win_idx;
    logic                  any_grant;
    logic                  pop_ok;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  push_q, push_d;
    logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
    logic [IDX_W-1:0]      push_src_q, push_src_d;
    logic [CRD_W-1:0]      credit_q, credit_d;
    logic                  err_q, err_d;

`ifdef FIFO_PUSH_ARB_LOCK_EN
    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
`else
    logic                  unused_last;
    assign unused_last = ^i_req_last;
`endif

    always_comb begin
        eligible = (credit_q != '0) ? i_req : '0;
`ifdef FIFO_PUSH_ARB_LOCK_EN
        if (state_q == LOCK) begin
            eligible = eligible & (NUM_REQ'(1) << owner_q);
        end
`endif
    end

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_priority_select (
        .i_req   (eligible),
        .i_ptr   (ptr_q),
        .o_grant (grant),
        .o_idx   (win_idx),
        .o_any   (any_grant)
    );

    always_comb begin
        // A pop at full credit has nothing to return.
        pop_ok      = i_fifo_pop & (credit_q != CRD_W'(FIFO_DEPTH));
        ptr_d       = any_grant ? win_idx : ptr_q;
        push_d      = any_grant;
        push_data_d = push_data_q;
        push_src_d  = push_src_q;
        if (any_grant) begin
            push_data_d = i_req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
            push_src_d  = win_idx;
        end
        credit_d    = credit_q - CRD_W'(any_grant) + CRD_W'(pop_ok);
        err_d       = err_q | (push_q & i_fifo_full & ~i_fifo_pop);
`ifdef FIFO_PUSH_ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB: begin
                if (any_grant && !i_req_last[win_idx]) begin
                    state_d = LOCK;
                    owner_d = win_idx;
                end
            end
            LOCK: begin
                // Pointer already sits on the owner, so the next burst rotates past it.
                if (any_grant && i_req_last[win_idx]) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            push_q      <= 1'b0;
            push_data_q <= '0;
            push_src_q  <= '0;
            credit_q    <= CRD_W'(FIFO_DEPTH);
            err_q       <= 1'b0;
`ifdef FIFO_PUSH_ARB_LOCK_EN
            state_q     <= ARB;
            owner_q     <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            push_src_q  <= push_src_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
`ifdef FIFO_PUSH_ARB_LOCK_EN
            state_q     <= state_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign o_grant     = grant;
    assign o_push      = push_q;
    assign o_push_data = push_data_q;
    assign o_push_src  = push_src_q;
    assign o_credit    = credit_q;
    assign o_err       = err_q;

endmodule
